// File: rtl/axi_lite_arb2.sv
// -----------------------------------------------------------------------------
// axi_lite_arb2
//   Two-requester front end for a single AXI4-Lite master port. One single-beat
//   request is accepted at a time; the block runs AR/R or AW/W/B on the bus and
//   returns read data and error status to the requester that was granted.
//   Only one transaction is ever outstanding, so responses are never reordered.
//
// Configuration macro:
//   ARB_RR_EN  defined   -> round-robin arbitration (pointer = port after the
//                           last grant, updated at accept)
//              undefined -> fixed priority, port 0 wins
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/ready/we [1:0]   per-port request handshake and direction
//   req_addr/wdata/wstrb       per-port request fields, port i in slice i
//   rsp_valid [1:0]            one-cycle completion pulse to the granted port
//   rsp_rdata, rsp_err         read data (0 for writes) and bus error
//   m_axi_aw*/w*/b*/ar*/r*     AXI4-Lite master channels
// -----------------------------------------------------------------------------
module axi_lite_arb2 #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_we,
  input  logic [2*ADDR_W-1:0]     req_addr,
  input  logic [2*DATA_W-1:0]     req_wdata,
  input  logic [2*DATA_W/8-1:0]   req_wstrb,
  output logic [1:0]              rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    rsp_err,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [ADDR_W-1:0]       m_axi_awaddr,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  output logic [DATA_W-1:0]       m_axi_wdata,
  output logic [DATA_W/8-1:0]     m_axi_wstrb,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  input  logic [1:0]              m_axi_bresp,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  output logic [ADDR_W-1:0]       m_axi_araddr,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  input  logic [DATA_W-1:0]       m_axi_rdata,
  input  logic [1:0]              m_axi_rresp
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_AR = 3'd1, S_R = 3'd2, S_AW = 3'd3, S_B = 3'd4, S_RESP = 3'd5
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_port, w_port_nxt;
  logic                r_arvalid, w_arvalid_nxt;
  logic [ADDR_W-1:0]   r_araddr, w_araddr_nxt;
  logic                r_rready, w_rready_nxt;
  logic                r_awvalid, w_awvalid_nxt;
  logic [ADDR_W-1:0]   r_awaddr, w_awaddr_nxt;
  logic                r_wvalid, w_wvalid_nxt;
  logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
  logic [STRB_W-1:0]   r_wstrb, w_wstrb_nxt;
  logic                r_bready, w_bready_nxt;
  logic [1:0]          r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_W-1:0]   r_rsp_rdata, w_rsp_rdata_nxt;
  logic                r_rsp_err, w_rsp_err_nxt;

  logic                w_win;
  logic                w_accept;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic [STRB_W-1:0]   w_sel_wstrb;
  logic [1:0]          w_port_oh;
  logic                w_aw_ok;
  logic                w_w_ok;

`ifdef ARB_RR_EN
  logic r_rr_ptr;

  // Pointer names the preferred port; the other port wins only if it is idle.
  assign w_win = req_valid[r_rr_ptr] ? r_rr_ptr : ~r_rr_ptr;

  // Round-robin pointer moves to the port after the one just granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= 1'b0;
    end else if (w_accept) begin
      r_rr_ptr <= ~w_win;
    end else begin
      r_rr_ptr <= r_rr_ptr;
    end
  end
`else
  assign w_win = req_valid[0] ? 1'b0 : 1'b1;
`endif

  // The winner is always a valid port when any port is valid, so the grant
  // itself is the handshake.
  assign w_accept    = (r_state == S_IDLE) && (|req_valid);
  assign w_sel_we    = w_win ? req_we[1] : req_we[0];
  assign w_sel_addr  = w_win ? req_addr[2*ADDR_W-1:ADDR_W]   : req_addr[ADDR_W-1:0];
  assign w_sel_wdata = w_win ? req_wdata[2*DATA_W-1:DATA_W]  : req_wdata[DATA_W-1:0];
  assign w_sel_wstrb = w_win ? req_wstrb[2*STRB_W-1:STRB_W]  : req_wstrb[STRB_W-1:0];
  assign w_port_oh   = r_port ? 2'b10 : 2'b01;

  // An address/data channel is done once its valid has dropped or is being taken now.
  assign w_aw_ok = (~r_awvalid) | m_axi_awready;
  assign w_w_ok  = (~r_wvalid)  | m_axi_wready;

  // Combinational one-hot grant, held low during reset.
  always_comb begin
    req_ready = 2'b00;
    if (w_accept && rst_n) begin
      req_ready = w_win ? 2'b10 : 2'b01;
    end else begin
      req_ready = 2'b00;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = w_accept ? (w_sel_we ? S_AW : S_AR) : S_IDLE;
      S_AR:    w_state_nxt = m_axi_arready ? S_R : S_AR;
      S_R:     w_state_nxt = m_axi_rvalid ? S_RESP : S_R;
      S_AW:    w_state_nxt = (w_aw_ok && w_w_ok) ? S_B : S_AW;
      S_B:     w_state_nxt = m_axi_bvalid ? S_RESP : S_B;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered bus and response outputs.
  always_comb begin
    w_port_nxt      = r_port;
    w_arvalid_nxt   = r_arvalid;
    w_araddr_nxt    = r_araddr;
    w_rready_nxt    = r_rready;
    w_awvalid_nxt   = r_awvalid;
    w_awaddr_nxt    = r_awaddr;
    w_wvalid_nxt    = r_wvalid;
    w_wdata_nxt     = r_wdata;
    w_wstrb_nxt     = r_wstrb;
    w_bready_nxt    = r_bready;
    w_rsp_valid_nxt = 2'b00;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_port_nxt = w_win;
          if (w_sel_we) begin
            w_awvalid_nxt = 1'b1;
            w_wvalid_nxt  = 1'b1;
            w_awaddr_nxt  = w_sel_addr;
            w_wdata_nxt   = w_sel_wdata;
            w_wstrb_nxt   = w_sel_wstrb;
          end else begin
            w_arvalid_nxt = 1'b1;
            w_araddr_nxt  = w_sel_addr;
          end
        end else begin
          w_port_nxt = r_port;
        end
      end
      S_AR: begin
        if (m_axi_arready) begin
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b1;
        end else begin
          w_arvalid_nxt = 1'b1;
        end
      end
      S_R: begin
        if (m_axi_rvalid) begin
          w_rready_nxt    = 1'b0;
          w_rsp_rdata_nxt = m_axi_rdata;
          w_rsp_err_nxt   = m_axi_rresp[1];
          w_rsp_valid_nxt = w_port_oh;
        end else begin
          w_rready_nxt = 1'b1;
        end
      end
      S_AW: begin
        // AW and W retire independently; B opens only after both are taken.
        w_awvalid_nxt = r_awvalid & ~m_axi_awready;
        w_wvalid_nxt  = r_wvalid & ~m_axi_wready;
        if (w_aw_ok && w_w_ok) begin
          w_bready_nxt = 1'b1;
        end else begin
          w_bready_nxt = 1'b0;
        end
      end
      S_B: begin
        if (m_axi_bvalid) begin
          w_bready_nxt    = 1'b0;
          w_rsp_rdata_nxt = {DATA_W{1'b0}};
          w_rsp_err_nxt   = m_axi_bresp[1];
          w_rsp_valid_nxt = w_port_oh;
        end else begin
          w_bready_nxt = 1'b1;
        end
      end
      S_RESP:  w_rsp_valid_nxt = 2'b00;
      default: w_rsp_valid_nxt = 2'b00;
    endcase
  end

  // Output and datapath registers; everything clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_port      <= 1'b0;
      r_arvalid   <= 1'b0;
      r_araddr    <= {ADDR_W{1'b0}};
      r_rready    <= 1'b0;
      r_awvalid   <= 1'b0;
      r_awaddr    <= {ADDR_W{1'b0}};
      r_wvalid    <= 1'b0;
      r_wdata     <= {DATA_W{1'b0}};
      r_wstrb     <= {STRB_W{1'b0}};
      r_bready    <= 1'b0;
      r_rsp_valid <= 2'b00;
      r_rsp_rdata <= {DATA_W{1'b0}};
      r_rsp_err   <= 1'b0;
    end else begin
      r_port      <= w_port_nxt;
      r_arvalid   <= w_arvalid_nxt;
      r_araddr    <= w_araddr_nxt;
      r_rready    <= w_rready_nxt;
      r_awvalid   <= w_awvalid_nxt;
      r_awaddr    <= w_awaddr_nxt;
      r_wvalid    <= w_wvalid_nxt;
      r_wdata     <= w_wdata_nxt;
      r_wstrb     <= w_wstrb_nxt;
      r_bready    <= w_bready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
    end
  end

  assign m_axi_arvalid = r_arvalid;
  assign m_axi_araddr  = r_araddr;
  assign m_axi_rready  = r_rready;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_awaddr  = r_awaddr;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = r_wstrb;
  assign m_axi_bready  = r_bready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_err       = r_rsp_err;

endmodule

// File: tb/tb_axi_lite_arb2.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_arb2
//   Directed bench for axi_lite_arb2. Stimulus pushes the expected completion
//   into a scoreboard queue; an independent monitor pops and compares whenever
//   rsp_valid is seen. A small configurable AXI4-Lite slave answers the bus.
// -----------------------------------------------------------------------------
module tb_axi_lite_arb2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, req_we;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wstrb;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;
  logic [1:0]  m_axi_bresp, m_axi_rresp;

  always #5 clk = ~clk;

  axi_lite_arb2 #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp)
  );

  // ---------------- slave model ----------------
  int          aw_dly = 0;
  int          w_dly  = 0;
  logic        r_hold = 1'b0;
  logic [31:0] cfg_rdata = 32'h0;
  logic [1:0]  cfg_rresp = 2'b00;
  logic [1:0]  cfg_bresp = 2'b00;
  int          s_aw_cnt, s_w_cnt;
  logic        s_aw_done, s_w_done, s_aw_d, s_w_d;

  assign m_axi_arready = 1'b1;
  assign m_axi_awready = (s_aw_cnt >= aw_dly);
  assign m_axi_wready  = (s_w_cnt >= w_dly);
  assign s_aw_d = s_aw_done | (m_axi_awvalid & m_axi_awready);
  assign s_w_d  = s_w_done  | (m_axi_wvalid & m_axi_wready);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_aw_cnt <= 0; s_w_cnt <= 0; s_aw_done <= 1'b0; s_w_done <= 1'b0;
      m_axi_bvalid <= 1'b0; m_axi_bresp <= 2'b00;
      m_axi_rvalid <= 1'b0; m_axi_rdata <= 32'h0; m_axi_rresp <= 2'b00;
    end else begin
      if (m_axi_awvalid && m_axi_awready) s_aw_cnt <= 0;
      else if (m_axi_awvalid)             s_aw_cnt <= s_aw_cnt + 1;
      if (m_axi_wvalid && m_axi_wready)   s_w_cnt <= 0;
      else if (m_axi_wvalid)              s_w_cnt <= s_w_cnt + 1;
      if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
      if (s_aw_d && s_w_d) begin
        m_axi_bvalid <= 1'b1; m_axi_bresp <= cfg_bresp;
        s_aw_done <= 1'b0; s_w_done <= 1'b0;
      end else begin
        s_aw_done <= s_aw_d; s_w_done <= s_w_d;
      end
      if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
      if (m_axi_arvalid && m_axi_arready && !r_hold) begin
        m_axi_rvalid <= 1'b1; m_axi_rdata <= cfg_rdata; m_axi_rresp <= cfg_rresp;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [1:0]  vld;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rsp_count = 0;
  int   last_rsp_cyc = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] vld, input logic [31:0] rdata, input logic err);
    exp_t e;
    e.vld = vld; e.rdata = rdata; e.err = err;
    sb_q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: every completion pulse is matched against the oldest expectation.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n === 1'b1 && rsp_valid !== 2'b00) begin
      rsp_count++;
      last_rsp_cyc = cyc;
      if (sb_q.size() == 0) begin
        chk("rsp_unexpected", {62'd0, rsp_valid}, 64'd0);
      end else begin
        e = sb_q.pop_front();
        chk("rsp_valid", {62'd0, rsp_valid}, {62'd0, e.vld});
        chk("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e.rdata});
        chk("rsp_err",   {63'd0, rsp_err},   {63'd0, e.err});
      end
    end
  end

  // ---------------- driver helpers ----------------
  // Called at a negedge; holds the request until granted, returns at the negedge after accept.
  task automatic issue(input int port, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb,
                       output int ready_cyc, output int acc_cyc);
    bit done = 1'b0;
    req_we[port] = we;
    req_addr[port*32 +: 32]  = addr;
    req_wdata[port*32 +: 32] = wdata;
    req_wstrb[port*4 +: 4]   = strb;
    req_valid[port] = 1'b1;
    ready_cyc = -1; acc_cyc = -1;
    for (int i = 0; i < 60 && !done; i++) begin
      #1;
      if (req_ready[port] === 1'b1) begin
        ready_cyc = cyc;
        @(posedge clk);
        @(negedge clk);
        acc_cyc = cyc;
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    req_valid[port] = 1'b0;
    if (!done) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb_q.size() != 0; i++) @(negedge clk);
    chk("drain_pending", sb_q.size(), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  int rc, ac, c0, rc1, ac1, base;
  logic [0:0] seq [4];

  initial begin
    rst_n = 1'b0; req_valid = 2'b00; req_we = 2'b00;
    req_addr = 64'd0; req_wdata = 64'd0; req_wstrb = 8'd0;

    // Reset: all outputs low, req_ready held low even with a request present.
    req_valid = 2'b01;
    #12;
    chk("rst_req_ready", req_ready, 64'd0);
    chk("rst_rsp_valid", rsp_valid, 64'd0);
    chk("rst_arvalid", m_axi_arvalid, 64'd0);
    chk("rst_awvalid", m_axi_awvalid, 64'd0);
    chk("rst_wvalid", m_axi_wvalid, 64'd0);
    chk("rst_rready", m_axi_rready, 64'd0);
    chk("rst_bready", m_axi_bready, 64'd0);
    chk("rst_rsp_rdata", rsp_rdata, 64'd0);
    req_valid = 2'b00;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // 1: port0 read, zero-wait slave.
    cfg_rdata = 32'hDEADBEEF; cfg_rresp = 2'b00;
    push(2'b01, 32'hDEADBEEF, 1'b0);
    issue(0, 1'b0, 32'h1000, 32'h0, 4'h0, rc, ac);
    chk("t1_arvalid", m_axi_arvalid, 64'd1);
    chk("t1_araddr", m_axi_araddr, 64'h1000);
    drain();
    chk("t1_latency", last_rsp_cyc, ac + 2);

    // 2: port1 write, awready delayed, wready immediate.
    aw_dly = 2;
    push(2'b10, 32'h0, 1'b0);
    issue(1, 1'b1, 32'h2004, 32'h55AA, 4'h3, rc, ac);
    chk("t2_awvalid0", m_axi_awvalid, 64'd1);
    chk("t2_wvalid0", m_axi_wvalid, 64'd1);
    chk("t2_awaddr", m_axi_awaddr, 64'h2004);
    chk("t2_wdata", m_axi_wdata, 64'h55AA);
    chk("t2_wstrb", m_axi_wstrb, 64'h3);
    chk("t2_bready0", m_axi_bready, 64'd0);
    @(negedge clk);
    chk("t2_wvalid1", m_axi_wvalid, 64'd0);
    chk("t2_awvalid1", m_axi_awvalid, 64'd1);
    chk("t2_bready1", m_axi_bready, 64'd0);
    @(negedge clk);
    chk("t2_awvalid2", m_axi_awvalid, 64'd1);
    chk("t2_bready2", m_axi_bready, 64'd0);
    @(negedge clk);
    chk("t2_awvalid3", m_axi_awvalid, 64'd0);
    chk("t2_bready3", m_axi_bready, 64'd1);
    drain();
    aw_dly = 0;

    // 3: error responses, and EXOKAY treated as success.
    cfg_rdata = 32'h12345678; cfg_rresp = 2'b10;
    push(2'b01, 32'h12345678, 1'b1);
    issue(0, 1'b0, 32'h3000, 32'h0, 4'h0, rc, ac);
    drain();
    cfg_bresp = 2'b11;
    push(2'b01, 32'h0, 1'b1);
    issue(0, 1'b1, 32'h3008, 32'hFFFF0000, 4'hC, rc, ac);
    drain();
    cfg_bresp = 2'b00;
    cfg_rdata = 32'hCAFE0001; cfg_rresp = 2'b01;
    push(2'b10, 32'hCAFE0001, 1'b0);
    issue(1, 1'b0, 32'h300C, 32'h0, 4'h0, rc, ac);
    drain();
    cfg_rresp = 2'b00;

    // 5: reset while waiting in R abandons the read.
    r_hold = 1'b1;
    issue(0, 1'b0, 32'h5000, 32'h0, 4'h0, rc, ac);
    @(negedge clk);
    chk("t5_rready", m_axi_rready, 64'd1);
    req_valid = 2'b01;
    rst_n = 1'b0;
    #1;
    chk("t5_rready_rst", m_axi_rready, 64'd0);
    chk("t5_arvalid_rst", m_axi_arvalid, 64'd0);
    chk("t5_araddr_rst", m_axi_araddr, 64'd0);
    chk("t5_req_ready_rst", req_ready, 64'd0);
    chk("t5_rsp_valid_rst", rsp_valid, 64'd0);
    req_valid = 2'b00;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; r_hold = 1'b0;
    @(negedge clk);
    cfg_rdata = 32'hA0A05555;
    push(2'b01, 32'hA0A05555, 1'b0);
    issue(0, 1'b0, 32'h5004, 32'h0, 4'h0, rc, ac);
    drain();

    // 6: AW and W taken together, then a queued read granted right after RESP.
    cfg_rdata = 32'h66660006;
    push(2'b01, 32'h0, 1'b0);
    push(2'b10, 32'h66660006, 1'b0);
    issue(0, 1'b1, 32'h6000, 32'h11223344, 4'hF, rc, c0);
    chk("t6_awvalid0", m_axi_awvalid, 64'd1);
    chk("t6_wvalid0", m_axi_wvalid, 64'd1);
    @(negedge clk);
    chk("t6_awvalid1", m_axi_awvalid, 64'd0);
    chk("t6_wvalid1", m_axi_wvalid, 64'd0);
    chk("t6_bready1", m_axi_bready, 64'd1);
    issue(1, 1'b0, 32'h6010, 32'h0, 4'h0, rc1, ac1);
    chk("t6_wr_rsp_cyc", last_rsp_cyc, c0 + 2);
    chk("t6_rd_ready_cyc", rc1, c0 + 3);
    drain();

    // 4: both ports requesting continuously for four transactions.
`ifdef ARB_RR_EN
    seq[0] = 1'b0; seq[1] = 1'b1; seq[2] = 1'b0; seq[3] = 1'b1;
`else
    seq[0] = 1'b0; seq[1] = 1'b0; seq[2] = 1'b0; seq[3] = 1'b0;
`endif
    cfg_rdata = 32'h00000044;
    for (int k = 0; k < 4; k++) push(seq[k] ? 2'b10 : 2'b01, 32'h00000044, 1'b0);
    req_we = 2'b00;
    req_addr = {32'h4100, 32'h4000};
    base = rsp_count;
    req_valid = 2'b11;
    for (int i = 0; i < 100 && (rsp_count - base) < 4; i++) begin
      @(negedge clk);
      #1;
    end
    req_valid = 2'b00;
    chk("t4_rsp_count", rsp_count - base, 64'd4);
    drain();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
